// File: rtl/comp_sar_ctrl_if.sv
// rtl/comp_sar_ctrl_if.sv - Handshake and analog-side signal bundle for the SAR controller
//
// Signals:
//   start_i    conversion request (sampled only while idle)
//   abort_i    abort of an in-progress conversion
//   settle_i   DAC settle cycles minus one, latched at start
//   comp_i     asynchronous comparator output, high when vp > vn
//   dac_code_o trial code to the external resistor DAC
//   busy_o     conversion in progress
//   done_o     one-cycle pulse when result_o is updated
//   result_o   last completed conversion result
//   valid_o    result_o holds a conversion completed since the last start
// Modports: slave = controller side, master = requester / analog side.
interface comp_sar_ctrl_if #(
    parameter int NBITS    = 8,
    parameter int SETTLE_W = 8
);
    logic                start_i;
    logic                abort_i;
    logic [SETTLE_W-1:0] settle_i;
    logic                comp_i;
    logic [NBITS-1:0]    dac_code_o;
    logic                busy_o;
    logic                done_o;
    logic [NBITS-1:0]    result_o;
    logic                valid_o;

    modport slave (
        input  start_i, abort_i, settle_i, comp_i,
        output dac_code_o, busy_o, done_o, result_o, valid_o
    );

    modport master (
        output start_i, abort_i, settle_i, comp_i,
        input  dac_code_o, busy_o, done_o, result_o, valid_o
    );
endinterface

// File: rtl/comp_sar_ctrl.sv
// rtl/comp_sar_ctrl.sv - Successive-approximation controller time-sharing the on-chip comparator
//
// Ports:
//   wb_clk_i  single clock for all logic
//   wb_rst_i  synchronous active-high reset, highest priority
//   bus       comp_sar_ctrl_if.slave: start/abort/settle/comp in, dac_code/busy/done/result/valid out
// Optional feature macro: COMP_SAR_MAJORITY_EN
//   defined   -> each decision takes 3 comparator samples, bit kept on 2-of-3 ones
//   undefined -> single-sample decision
module comp_sar_ctrl #(
    parameter int NBITS    = 8,
    parameter int SETTLE_W = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    comp_sar_ctrl_if.slave    bus
);
    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SYNC   = 2'd2,
        DECIDE = 2'd3
    } state_t;

    state_t              state;
    logic [NBITS-1:0]    dac_code;
    logic [NBITS-1:0]    result;
    logic                busy;
    logic                done;
    logic                valid;
    logic [IDX_W-1:0]    idx;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] cnt;
    logic [1:0]          phase;     // cycle count inside SYNC / DECIDE
    logic                comp_s1;
    logic                comp_s;
`ifdef COMP_SAR_MAJORITY_EN
    logic [1:0]          votes;     // ones seen in earlier DECIDE cycles
`endif

    logic             keep;
    logic             last_phase;
    logic [NBITS-1:0] cur_bit;
    logic [NBITS-1:0] code_next;

    always_comb begin
        keep       = comp_s;
        last_phase = 1'b1;
`ifdef COMP_SAR_MAJORITY_EN
        keep       = ((votes + 2'(comp_s)) >= 2'd2);
        last_phase = (phase == 2'd2);
`endif
        cur_bit    = NBITS'(1) << idx;
        code_next  = keep ? dac_code : (dac_code & ~cur_bit);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            dac_code <= '0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            idx      <= '0;
            settle_q <= '0;
            cnt      <= '0;
            phase    <= '0;
            comp_s1  <= 1'b0;
            comp_s   <= 1'b0;
`ifdef COMP_SAR_MAJORITY_EN
            votes    <= '0;
`endif
        end else begin
            comp_s1 <= bus.comp_i;
            comp_s  <= comp_s1;
            done    <= 1'b0;
            if (state == IDLE) begin
                // Abort is meaningless here, so start always wins.
                if (bus.start_i) begin
                    dac_code <= NBITS'(1) << (NBITS - 1);
                    idx      <= IDX_W'(NBITS - 1);
                    settle_q <= bus.settle_i;
                    cnt      <= bus.settle_i;
                    busy     <= 1'b1;
                    valid    <= 1'b0;
                    state    <= SETTLE;
                end
            end else if (bus.abort_i) begin
                state    <= IDLE;
                busy     <= 1'b0;
                dac_code <= '0;
            end else begin
                case (state)
                    SETTLE: begin
                        if (cnt == '0) begin
                            state <= SYNC;
                            phase <= 2'd0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    SYNC: begin
                        // Two cycles let the new DAC level reach comp_s.
                        if (phase == 2'd1) begin
                            state <= DECIDE;
                            phase <= 2'd0;
`ifdef COMP_SAR_MAJORITY_EN
                            votes <= '0;
`endif
                        end else begin
                            phase <= 2'd1;
                        end
                    end
                    DECIDE: begin
                        if (!last_phase) begin
                            phase <= phase + 2'd1;
`ifdef COMP_SAR_MAJORITY_EN
                            votes <= votes + 2'(comp_s);
`endif
                        end else if (idx != '0) begin
                            dac_code <= code_next | (cur_bit >> 1);
                            idx      <= idx - 1'b1;
                            cnt      <= settle_q;
                            state    <= SETTLE;
                        end else begin
                            dac_code <= code_next;
                            result   <= code_next;
                            valid    <= 1'b1;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dac_code_o = dac_code;
    assign bus.result_o   = result;
    assign bus.busy_o     = busy;
    assign bus.done_o     = done;
    assign bus.valid_o    = valid;
endmodule

// File: tb/tb_comp_sar_ctrl.sv
// tb/tb_comp_sar_ctrl.sv - Self-checking bench for comp_sar_ctrl
module tb_comp_sar_ctrl;
    localparam int NB = 8;
`ifdef COMP_SAR_MAJORITY_EN
    localparam int PER_BIT_EXTRA = 6;
    localparam bit MAJ = 1'b1;
`else
    localparam int PER_BIT_EXTRA = 4;
    localparam bit MAJ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    comp_sar_ctrl_if #(.NBITS(NB), .SETTLE_W(8)) bus ();

    comp_sar_ctrl #(.NBITS(NB), .SETTLE_W(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    logic [7:0] vin_r     = 8'h00;
    logic       force_en  = 1'b0;
    logic       force_val = 1'b0;
    assign bus.comp_i = force_en ? force_val : (vin_r >= bus.dac_code_o);

    int checks   = 0;
    int failures = 0;

    int          done_cyc, done_cnt, busy_cnt;
    logic [7:0]  trials[$];
    logic        post_busy, post_valid;
    logic        snap_busy, snap_valid;
    logic [7:0]  snap_dac, snap_result;
    logic [7:0]  exp_trials[NB];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plain binary-search reference: greedily keep each bit while code <= vin.
    // glitch_msb forces the first decision to 0 when a single sample decides it.
    function automatic logic [7:0] sar_model(input logic [7:0] vin, input bit glitch_msb);
        logic [7:0] code;
        logic [7:0] trial;
        code = 8'h00;
        for (int i = NB - 1; i >= 0; i--) begin
            trial = code | (8'h01 << i);
            exp_trials[NB-1-i] = trial;
            if (vin >= trial && !(glitch_msb && !MAJ && i == NB - 1))
                code = trial;
        end
        return code;
    endfunction

    // Cycle 0 is the cycle with start_i high; outputs sampled 1 time unit after each edge.
    task automatic run(input logic [7:0] vin, input logic [7:0] settle, input bit hold,
                       input int abort_at, input int chg_at, input int glitch_at);
        logic [8:0] prev;
        vin_r = vin;
        bus.settle_i = settle;
        trials.delete();
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; prev = 9'h1FF;
        post_busy = 1'bx; post_valid = 1'bx;
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            bus.start_i = hold;
            bus.abort_i = (c == abort_at);
            force_en = (c == glitch_at);
            force_val = 1'b0;
            if (c == chg_at) bus.settle_i = 8'd9;
            if (bus.done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (bus.busy_o) begin
                busy_cnt++;
                if ({1'b0, bus.dac_code_o} != prev) trials.push_back(bus.dac_code_o);
                prev = {1'b0, bus.dac_code_o};
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                post_busy = bus.busy_o;
                post_valid = bus.valid_o;
                break;
            end
            if (abort_at >= 0 && c == abort_at + 1) begin
                snap_busy = bus.busy_o; snap_dac = bus.dac_code_o;
                snap_valid = bus.valid_o; snap_result = bus.result_o;
                break;
            end
        end
        bus.start_i = 1'b0;
        force_en = 1'b0;
        // Clear any conversion left running (held start); ignored when idle.
        bus.abort_i = 1'b1;
        @(posedge clk); #1;
        bus.abort_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] exp_res;
        logic [7:0] v, s;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.settle_i = 8'd2;

        // Reset with comparator toggling
        force_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            force_val = ~force_val;
        end
        rst = 1'b0;
        force_en = 1'b0;
        check("rst_dac", bus.dac_code_o, 0);
        check("rst_result", bus.result_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_valid", bus.valid_o, 0);
        repeat (3) @(posedge clk);
        #1 check("idle_busy", bus.busy_o, 0);

        // Nominal conversion vin=0xA5, settle=2
        exp_res = sar_model(8'hA5, 1'b0);
        run(8'hA5, 8'd2, 1'b0, -1, -1, -1);
        check("conv_ntrials", trials.size(), NB);
        for (int i = 0; i < NB; i++)
            if (i < trials.size()) check($sformatf("conv_trial%0d", i), trials[i], exp_trials[i]);
        check("conv_done_cyc", done_cyc, NB * (2 + PER_BIT_EXTRA) + 1);
        check("conv_done_cnt", done_cnt, 1);
        check("conv_busy_cnt", busy_cnt, NB * (2 + PER_BIT_EXTRA));
        check("conv_result", bus.result_o, exp_res);
        check("conv_valid", bus.valid_o, 1);
        check("conv_dac_hold", bus.dac_code_o, exp_res);

        // Extremes
        run(8'hFF, 8'd2, 1'b0, -1, -1, -1);
        check("max_result", bus.result_o, 8'hFF);
        run(8'h00, 8'd2, 1'b0, -1, -1, -1);
        check("min_result", bus.result_o, 8'h00);
        run(8'h5A, 8'd0, 1'b0, -1, -1, -1);
        check("s0_done_cyc", done_cyc, NB * PER_BIT_EXTRA + 1);
        check("s0_result", bus.result_o, 8'h5A);

        // Abort in cycle 20; previous result is 0x5A
        run(8'h3C, 8'd2, 1'b0, 20, -1, -1);
        check("abort_busy", snap_busy, 0);
        check("abort_dac", snap_dac, 0);
        check("abort_valid", snap_valid, 0);
        check("abort_result", snap_result, 8'h5A);
        check("abort_no_done", done_cnt, 0);

        // Start held high: new conversion accepted in the done cycle
        run(8'hA5, 8'd2, 1'b1, -1, -1, -1);
        check("hold_done_cyc", done_cyc, NB * (2 + PER_BIT_EXTRA) + 1);
        check("hold_done_cnt", done_cnt, 1);
        check("hold_restart_busy", post_busy, 1);
        check("hold_restart_valid", post_valid, 0);

        // settle_i change mid-conversion has no effect
        run(8'hA5, 8'd2, 1'b0, -1, 10, -1);
        check("chg_done_cyc", done_cyc, NB * (2 + PER_BIT_EXTRA) + 1);
        check("chg_result", bus.result_o, 8'hA5);

        // Comparator glitch on the first MSB decision sample
        run(8'hA5, 8'd2, 1'b0, -1, -1, 4);
        check("glitch_result", bus.result_o, sar_model(8'hA5, 1'b1));
        check("glitch_done_cyc", done_cyc, NB * (2 + PER_BIT_EXTRA) + 1);

        // Randomized conversions
        for (int k = 0; k < 6; k++) begin
            v = 8'($urandom_range(0, 255));
            s = 8'($urandom_range(0, 6));
            exp_res = sar_model(v, 1'b0);
            run(v, s, 1'b0, -1, -1, -1);
            check($sformatf("rnd%0d_result", k), bus.result_o, exp_res);
            check($sformatf("rnd%0d_done_cyc", k), done_cyc, NB * (int'(s) + PER_BIT_EXTRA) + 1);
            check($sformatf("rnd%0d_valid", k), bus.valid_o, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
